// File: rtl/score_render_pkg.sv
// Shared constants for the score overlay: sprite geometry, the blank-digit
// code and the winner encoding.
package score_render_pkg;

    localparam int unsigned SPRITE_W    = 4;
    localparam int unsigned SPRITE_H    = 7;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

    typedef enum logic {
        WINNER_LEFT  = 1'b0,
        WINNER_RIGHT = 1'b1
    } winner_e;

endpackage

// File: rtl/score_render_keeper.sv
// score_keeper: left/right point counters saturating at WIN_SCORE, the
// game_over flag (raised the cycle after a score reaches WIN_SCORE) and the
// winner latch. new_game outranks any coincident point pulse.
module score_keeper
    import score_render_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_l,
    input  logic       point_r,
    input  logic       new_game,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    winner_e winner_q;
    logic    l_at_win;
    logic    r_at_win;

    // Win detection and enum-to-port mapping
    always_comb begin
        l_at_win = (score_l == WIN_SCORE);
        r_at_win = (score_r == WIN_SCORE);
        winner   = winner_q;
    end

    // Score counters, game_over and winner latch
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            winner_q  <= WINNER_LEFT;
        end else if (!game_over) begin
            // Saturate: a pulse in the cycle before game_over rises must not overshoot.
            if (point_l && (score_l < WIN_SCORE)) score_l <= score_l + 4'd1;
            if (point_r && (score_r < WIN_SCORE)) score_r <= score_r + 4'd1;
            if (l_at_win || r_at_win) begin
                game_over <= 1'b1;
                winner_q  <= l_at_win ? WINNER_LEFT : WINNER_RIGHT;
            end
        end
    end

endmodule

// File: rtl/score_render.sv
// score_render: two-digit score overlay. Scores are kept by score_keeper;
// this module shadows them once per frame and runs a 3-stage pixel pipeline
// (box decode -> external scoreboard ROM -> pixel register).
// Optional feature: define SCORE_BLINK_EN to blink the winner's digit
// on alternate 32-frame periods while game_over is high.
module score_render
    import score_render_pkg::*;
#(
    parameter logic [9:0]  LEFT_X     = 10'd256,
    parameter logic [9:0]  RIGHT_X    = 10'd352,
    parameter logic [9:0]  TOP_Y      = 10'd16,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter logic [3:0]  WIN_SCORE  = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_l,
    input  logic       point_r,
    input  logic       new_game,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       pix_valid,
    output logic [3:0] sb_score,
    output logic [2:0] sb_x,
    output logic [2:0] sb_y,
    input  logic [2:0] sb_dout,
    output logic [2:0] pix_out,
    output logic       pix_on,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    localparam logic [9:0] BOX_W = 10'(SPRITE_W << SCALE_LOG2);
    localparam logic [9:0] BOX_H = 10'(SPRITE_H << SCALE_LOG2);

    logic [3:0] disp_l;
    logic [3:0] disp_r;
    logic       frame_start;
    logic [9:0] dx_l;
    logic [9:0] dx_r;
    logic [9:0] dy;
    logic       in_l;
    logic       in_r;
    logic       blank_l;
    logic       blank_r;
    logic [3:0] sb_score_d;
    logic [2:0] sb_x_d;
    logic [2:0] sb_y_d;
    logic       hit_d;
    logic       hit1;
    logic       hit2;

    score_keeper #(
        .WIN_SCORE(WIN_SCORE)
    ) u_keeper (
        .clk      (clk),
        .rst      (rst),
        .point_l  (point_l),
        .point_r  (point_r),
        .new_game (new_game),
        .score_l  (score_l),
        .score_r  (score_r),
        .game_over(game_over),
        .winner   (winner)
    );

`ifdef SCORE_BLINK_EN
    logic [5:0] frame_cnt;

    // Frame counter driving the winner blink, advanced at each frame origin
    always_ff @(posedge clk) begin
        if (rst || new_game) frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
    end

    // Blank the winner's digit during the upper half of each 64-frame cycle
    always_comb begin
        blank_l = game_over && frame_cnt[5] && (winner == WINNER_LEFT);
        blank_r = game_over && frame_cnt[5] && (winner == WINNER_RIGHT);
    end
`else
    // Steady display: digits are never blanked
    always_comb begin
        blank_l = 1'b0;
        blank_r = 1'b0;
    end
`endif

    // Stage-1 decode: 10-bit offsets wrap for pixels left/above a box, so a
    // single unsigned compare against the box size covers both bounds.
    always_comb begin
        frame_start = (hcount == '0) && (vcount == '0);
        dx_l        = hcount - LEFT_X;
        dx_r        = hcount - RIGHT_X;
        dy          = vcount - TOP_Y;
        in_l        = pix_valid && (dy < BOX_H) && (dx_l < BOX_W);
        in_r        = pix_valid && (dy < BOX_H) && (dx_r < BOX_W);
        sb_score_d  = BLANK_DIGIT;
        sb_x_d      = '0;
        sb_y_d      = '0;
        hit_d       = 1'b0;
        if (in_l) begin
            sb_score_d = disp_l;
            sb_x_d     = 3'(dx_l >> SCALE_LOG2);
            sb_y_d     = 3'(dy >> SCALE_LOG2);
            hit_d      = !blank_l;
        end else if (in_r) begin
            sb_score_d = disp_r;
            sb_x_d     = 3'(dx_r >> SCALE_LOG2);
            sb_y_d     = 3'(dy >> SCALE_LOG2);
            hit_d      = !blank_r;
        end
    end

    // Display shadows reload only at the frame origin to avoid torn digits
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_l <= '0;
            disp_r <= '0;
        end else if (frame_start) begin
            disp_l <= score_l;
            disp_r <= score_r;
        end
    end

    // Pixel pipeline: ROM address (stage 1), hit alignment, output pixel (stage 3)
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_score <= BLANK_DIGIT;
            sb_x     <= '0;
            sb_y     <= '0;
            hit1     <= 1'b0;
            hit2     <= 1'b0;
            pix_on   <= 1'b0;
            pix_out  <= '0;
        end else begin
            sb_score <= sb_score_d;
            sb_x     <= sb_x_d;
            sb_y     <= sb_y_d;
            hit1     <= hit_d;
            hit2     <= hit1;
            pix_on   <= hit2 && (sb_dout != '0);
            pix_out  <= (hit2 && (sb_dout != '0)) ? sb_dout : '0;
        end
    end

endmodule
